sum_bcd_display: RTL and testbench
==================================

Name: sum_bcd_display

Overview:
- Downstream stage of the 4-bit adder lab block.
- Consumes the (WIDTH+1)-bit sum through a valid/ready handshake and converts it to two BCD digits with a serial double-dabble FSM.
- Drives a two-digit, time-multiplexed, active-low 7-segment display showing the last converted result.

Parameters:
- WIDTH, 4, adder operand width; the sum input is WIDTH+1 bits. Legal range 1..5 (sum ≤ 62, fits two digits).
- REFRESH_DIV, 50000, clocks per digit slot in the display scan. Minimum 2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sum_in  in  WIDTH+1  unsigned sum from the adder.
- in_valid  in  1  sum_in is valid this cycle.
- in_ready  out  1  block can accept a sum; high only in IDLE.
- bcd_tens  out  4  latched tens digit.
- bcd_ones  out  4  latched ones digit.
- out_valid  out  1  one-cycle pulse when bcd_tens/bcd_ones update.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- an  out  2  active-low digit enables; an[0]=ones, an[1]=tens.

Behaviour:
Reset (async assert, sync-safe release):
- state=IDLE, in_ready=1, bcd_tens=0, bcd_ones=0, out_valid=0.
- seg=7'b1111111, an=2'b11, refresh counter=0, digit_sel=0 (ones).

FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1.
  - On in_valid && in_ready at a clock edge (capture edge, E0): latch sum_in into the shift register, clear BCD scratch, bit counter=WIDTH+1, go to SHIFT.
- SHIFT: in_ready=0.
  - Each edge: add 3 to every scratch nibble ≥5, then shift {scratch, shift_reg} left by 1, decrement the counter.
  - After WIDTH+1 shifts (edge E(WIDTH+1)), go to DONE.
- DONE:
  - Entered with bcd_tens/bcd_ones loaded from the scratch on the same edge.
  - out_valid=1 for exactly this cycle; next edge goes to IDLE.

Latency:
- out_valid is high in the cycle following edge E(WIDTH+2), counted from the capture edge.
- For WIDTH=4 that is 6 edges.
- in_ready rises one cycle after out_valid; throughput is one sum per WIDTH+4 cycles.

Handshake rules:
- in_valid while in_ready=0 is ignored; no queueing. Upstream must hold in_valid until acceptance.
- sum_in is sampled only at the capture edge; later changes do not affect the conversion in flight.

Arithmetic:
- Result digits are always 0..9.
- bcd_tens*10 + bcd_ones == captured sum_in, for every sum_in in 0..2^(WIDTH+1)-1.

Display scan:
- The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
- At wrap to 0, digit_sel toggles.
- seg and an are registered every clock from digit_sel and the latched digits:
  - digit_sel=0 → an=2'b10, seg=code(bcd_ones).
  - digit_sel=1 → an=2'b01, seg=code(bcd_tens).
- First clock after reset release: an=2'b10, seg=7'b1000000 ("0").
- Decode codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Others 1111111 (unreachable).
- The display keeps showing the previous result throughout a conversion; it updates the clock after DONE.

Boundary conditions:
- Reset mid-SHIFT or in DONE: conversion aborted, no out_valid, outputs take reset values.
- sum_in=0 → 0,0.
- Maximum sum, 30 for WIDTH=4 → 3,0.
- in_valid held high continuously: a new sum is accepted on each return to IDLE.

Optional Feature:
- Macro: SUM_BCD_LEADING_ZERO_BLANK_EN.
- Defined: when digit_sel=1 and bcd_tens==0, seg=7'b1111111 and an=2'b01 (tens slot blank, timing unchanged).
- Undefined: a tens digit of 0 is shown as "0".
- The ones digit is never blanked.

Test Plan:
- Reset, then sum_in=5 with in_valid for 1 cycle → in_ready=0 next cycle; out_valid pulse 6 edges after capture; tens=0, ones=5; in_ready=1 one cycle later.
- Sums 24, 27, 13, 30 and 0 back-to-back with in_valid held high → each accepted only when in_ready=1; results (2,4), (2,7), (1,3), (3,0), (0,0); out_valid pulses exactly 5 times.
- Sweep sum_in 0..31 (WIDTH=4) → bcd_tens*10+bcd_ones==sum_in, all digits ≤9.
- REFRESH_DIV=4 after latching 18 → an alternates 10/01 every 4 clocks; seg=0000000 under an=10 and 1111001 under an=01.
- Capture 22, deassert rst_n 2 edges into SHIFT → all outputs at reset values immediately; no out_valid after release; bcd stays 0,0.
- Macro defined, latch 7, REFRESH_DIV=4 → an=01 slot seg=1111111; an=10 slot seg=1111000. Macro undefined → an=01 slot seg=1000000.

Source files
------------

// File: rtl/sum_bcd_display.sv
// Two-digit BCD converter and 7-segment scan driver for the adder sum.
// Optional SUM_BCD_LEADING_ZERO_BLANK_EN blanks a zero tens digit on the display.
module sum_bcd_display #(
    parameter int WIDTH       = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH:0]   sum_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             out_valid,
    output logic [6:0]       seg,
    output logic [1:0]       an
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] N_SHIFT = CNT_W'(WIDTH + 1);
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_shift;
    logic [7:0]       r_scratch;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_out_valid;
    logic [REF_W-1:0] r_ref_cnt;
    logic             r_digit_sel;
    logic [6:0]       r_seg;
    logic [1:0]       r_an;

    logic [7:0]       w_adj;
    logic [6:0]       w_ones_seg;
    logic [6:0]       w_tens_seg;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
    always_comb begin
        w_adj[3:0] = (r_scratch[3:0] >= 4'd5) ? r_scratch[3:0] + 4'd3 : r_scratch[3:0];
        w_adj[7:4] = (r_scratch[7:4] >= 4'd5) ? r_scratch[7:4] + 4'd3 : r_scratch[7:4];
        w_ones_seg = seg_code(r_ones);
`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
        w_tens_seg = (r_tens == 4'd0) ? 7'b1111111 : seg_code(r_tens);
`else
        w_tens_seg = seg_code(r_tens);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_scratch   <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_tens      <= '0;
            r_ones      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (in_valid && r_in_ready) begin
                        r_shift    <= sum_in;
                        r_scratch  <= '0;
                        r_cnt      <= N_SHIFT;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // The last shift lands in r_scratch; the following edge publishes it.
                    if (r_cnt != '0) begin
                        {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_tens      <= r_scratch[7:4];
                        r_ones      <= r_scratch[3:0];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Display scan runs freely, independent of the converter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt   <= '0;
            r_digit_sel <= 1'b0;
            r_seg       <= 7'b1111111;
            r_an        <= 2'b11;
        end else begin
            if (r_ref_cnt == REF_MAX) begin
                r_ref_cnt   <= '0;
                r_digit_sel <= ~r_digit_sel;
            end else begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
            r_an  <= r_digit_sel ? 2'b01 : 2'b10;
            r_seg <= r_digit_sel ? w_tens_seg : w_ones_seg;
        end
    end

    assign in_ready  = r_in_ready;
    assign bcd_tens  = r_tens;
    assign bcd_ones  = r_ones;
    assign out_valid = r_out_valid;
    assign seg       = r_seg;
    assign an        = r_an;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Directed bench for sum_bcd_display: vector table plus hand-written handshake,
// display-scan and reset sequences. Honours SUM_BCD_LEADING_ZERO_BLANK_EN.
module tb_sum_bcd_display;

    localparam int WIDTH       = 4;
    localparam int REFRESH_DIV = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [WIDTH:0] sum_in = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     bcd_tens;
    logic [3:0]     bcd_ones;
    logic           out_valid;
    logic [6:0]     seg;
    logic [1:0]     an;

    int n_tests = 0;
    int n_fail  = 0;

    sum_bcd_display #(.WIDTH(WIDTH), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid),
        .in_ready(in_ready), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
        .out_valid(out_valid), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int tens;
        int ones;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: exp_seg = 7'b1000000;
            1: exp_seg = 7'b1111001;
            2: exp_seg = 7'b0100100;
            3: exp_seg = 7'b0110000;
            4: exp_seg = 7'b0011001;
            5: exp_seg = 7'b0010010;
            6: exp_seg = 7'b0000010;
            7: exp_seg = 7'b1111000;
            8: exp_seg = 7'b0000000;
            9: exp_seg = 7'b0010000;
            default: exp_seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_tens_seg(input int d);
`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
        exp_tens_seg = (d == 0) ? 7'b1111111 : exp_seg(d);
`else
        exp_tens_seg = exp_seg(d);
`endif
    endfunction

    // One full conversion; lat = edges from capture to out_valid (20 on timeout).
    task automatic convert(input int s, output int lat, output int tens, output int ones);
        int budget;
        budget = 0;
        while (!in_ready && budget < 20) begin
            tick();
            budget++;
        end
        check("ready_before_capture", in_ready, 1);
        sum_in   = (WIDTH+1)'(s);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sum_in   = ~sum_in;
        check("ready_low_after_capture", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        tens = int'(bcd_tens);
        ones = int'(bcd_ones);
        tick();
        check("out_valid_one_cycle", out_valid, 0);
        check("ready_after_done", in_ready, 1);
    endtask

    task automatic disp_check(input int tens, input int ones);
        logic [1:0] prev;
        logic [1:0] cur;
        int budget;
        prev = an;
        budget = 0;
        while (an == prev && budget < 2 * REFRESH_DIV + 2) begin
            tick();
            budget++;
        end
        check("an_toggles", an != prev, 1);
        cur = an;
        for (int slot = 0; slot < 4; slot++) begin
            for (int j = 0; j < REFRESH_DIV; j++) begin
                check("scan_an", an, cur);
                check("scan_seg", seg, (cur == 2'b10) ? exp_seg(ones) : exp_tens_seg(tens));
                tick();
            end
            cur = {cur[0], cur[1]};
        end
    endtask

    initial begin
        vec_t vecs[12];
        int   lat, t, o, acc_i, ov_i, last_c, extra;
        logic will_acc;
        int   b2b_sum[5];
        int   b2b_tens[5];
        int   b2b_ones[5];

        vecs[0]  = '{0, 0, 0};   vecs[1]  = '{5, 0, 5};   vecs[2]  = '{9, 0, 9};
        vecs[3]  = '{10, 1, 0};  vecs[4]  = '{19, 1, 9};  vecs[5]  = '{24, 2, 4};
        vecs[6]  = '{27, 2, 7};  vecs[7]  = '{13, 1, 3};  vecs[8]  = '{30, 3, 0};
        vecs[9]  = '{31, 3, 1};  vecs[10] = '{18, 1, 8};  vecs[11] = '{22, 2, 2};
        b2b_sum  = '{24, 27, 13, 30, 0};
        b2b_tens = '{2, 2, 1, 3, 0};
        b2b_ones = '{4, 7, 3, 0, 0};

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_tens", bcd_tens, 0);
        check("rst_ones", bcd_ones, 0);
        check("rst_seg", seg, 7'b1111111);
        check("rst_an", an, 2'b11);
        tick();
        rst_n = 1'b1;
        tick();
        check("first_an", an, 2'b10);
        check("first_seg", seg, 7'b1000000);

        // Single conversion of 5
        convert(5, lat, t, o);
        check("latency_5", lat, 6);
        check("tens_5", t, 0);
        check("ones_5", o, 5);

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].sum, lat, t, o);
            check("vec_latency", lat, 6);
            check("vec_tens", t, vecs[i].tens);
            check("vec_ones", o, vecs[i].ones);
        end

        for (int s = 0; s < 32; s++) begin
            convert(s, lat, t, o);
            check("sweep_value", t * 10 + o, s);
            check("sweep_digits_le9", (t <= 9) && (o <= 9), 1);
        end

        // Back-to-back with in_valid held high
        acc_i = 0; ov_i = 0; last_c = 0;
        sum_in = (WIDTH+1)'(b2b_sum[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 100 && ov_i < 5; c++) begin
            will_acc = in_valid && in_ready;
            tick();
            if (will_acc) begin
                acc_i++;
                if (acc_i < 5) sum_in = (WIDTH+1)'(b2b_sum[acc_i]);
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                check("b2b_tens", bcd_tens, b2b_tens[ov_i]);
                check("b2b_ones", bcd_ones, b2b_ones[ov_i]);
                check("b2b_ready_low", in_ready, 0);
                if (ov_i > 0) check("b2b_period", c - last_c, WIDTH + 4);
                last_c = c;
                ov_i++;
            end
        end
        in_valid = 1'b0;
        check("b2b_pulses", ov_i, 5);
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid) extra++;
        end
        check("b2b_no_extra", extra, 0);

        // Display scan
        convert(18, lat, t, o);
        disp_check(1, 8);
        convert(7, lat, t, o);
        disp_check(0, 7);

        // Reset two edges into SHIFT
        sum_in = (WIDTH+1)'(22);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_tens", bcd_tens, 0);
        check("abort_ones", bcd_ones, 0);
        check("abort_seg", seg, 7'b1111111);
        check("abort_an", an, 2'b11);
        tick();
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_valid) extra++;
        end
        check("abort_no_out_valid", extra, 0);
        check("abort_tens_hold", bcd_tens, 0);
        check("abort_ones_hold", bcd_ones, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
